// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit FIFO slice.
//   drain_state_e : drain FSM states (IDLE, LOAD, WAIT_ACK)
//   BYTE_W_DEF    : default data byte width
//   DEPTH_DEF     : default FIFO depth (power of two, >= 2)
//   clog2()       : pointer width for a given depth
package uart_pkg;

    localparam int BYTE_W_DEF = 8;
    localparam int DEPTH_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD     = 2'd1,
        WAIT_ACK = 2'd2
    } drain_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Bundle of the producer-side and transmitter-side signals of uart_tx_fifo.
//   master : environment (producer + 8N1 transmitter)
//   slave  : the FIFO itself
// Signals: flush, wr_en, wr_data, full, empty, count, ovf,
//          tx_load, tx_data, load_ok.
interface uart_tx_fifo_if
    import uart_pkg::*;
#(
    parameter int BYTE_W = BYTE_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) ();

    localparam int CW = clog2(DEPTH) + 1;

    logic              flush;
    logic              wr_en;
    logic [BYTE_W-1:0] wr_data;
    logic              full;
    logic              empty;
    logic [CW-1:0]     count;
    logic              ovf;
    logic              tx_load;
    logic [BYTE_W-1:0] tx_data;
    logic              load_ok;

    modport master (
        output flush, wr_en, wr_data, load_ok,
        input  full, empty, count, ovf, tx_load, tx_data
    );

    modport slave (
        input  flush, wr_en, wr_data, load_ok,
        output full, empty, count, ovf, tx_load, tx_data
    );

endinterface

// File: rtl/uart_fifo_mem.sv
// Simple dual-port register array: synchronous write, asynchronous read.
// Contents are deliberately not reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational from raddr)
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int BYTE_W = BYTE_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [clog2(DEPTH)-1:0]  waddr,
    input  logic [BYTE_W-1:0]        wdata,
    input  logic [clog2(DEPTH)-1:0]  raddr,
    output logic [BYTE_W-1:0]        rdata
);

    logic [BYTE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 transmitter. The producer writes one byte per
// cycle; a drain FSM pops a byte whenever the transmitter reports idle and
// presents it with a single-cycle registered load strobe.
//   sys_clk : clock, all state on the rising edge
//   rst_n   : asynchronous active-low reset
//   bus     : uart_tx_fifo_if.slave (flush, write port, status, tx handshake)
// DEPTH must be a power of two and at least 2; the interface instance must
// carry the same BYTE_W/DEPTH as this module.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a queued byte and load_ok = 1
// LOAD     | tx_load high for exactly this cycle, byte on tx_data
// WAIT_ACK | waiting for load_ok = 0 (transmitter took the byte)
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int BYTE_W = BYTE_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic           sys_clk,
    input  logic           rst_n,
    uart_tx_fifo_if.slave  bus
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    drain_state_e      state_q, state_d;
    logic [AW-1:0]     rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic              ovf_q;
    logic              tx_load_q, load_d;
    logic [BYTE_W-1:0] tx_data_q, rd_data;
    logic              full, empty;
    logic              pop, push, drop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // A write into a full FIFO still lands when the same edge pops, since
    // the slot being vacated is the one wr_ptr points at.
    assign push    = bus.wr_en && !bus.flush && (!full || pop);
    assign drop    = bus.wr_en && !bus.flush && full && !pop;
    assign count_d = count_q + CW'(push) - CW'(pop);

    uart_fifo_mem #(
        .BYTE_W (BYTE_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (sys_clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (bus.wr_data),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

    always_comb begin
        state_d = state_q;
        load_d  = 1'b0;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty && bus.load_ok) begin
                    pop     = 1'b1;
                    load_d  = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (!bus.load_ok) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (bus.flush) begin
            state_d = IDLE;
            load_d  = 1'b0;
            pop     = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tx_load_q <= 1'b0;
            tx_data_q <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_load_q <= load_d;
            // tx_data is left alone by flush: a byte already presented stays.
            if (pop) begin
                tx_data_q <= rd_data;
            end
            if (bus.flush) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
                ovf_q    <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + AW'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + AW'(1);
                end
                count_q <= count_d;
                if (drop) begin
                    ovf_q <= 1'b1;
                end
            end
        end
    end

    assign bus.full    = full;
    assign bus.empty   = empty;
    assign bus.count   = count_q;
    assign bus.ovf     = ovf_q;
    assign bus.tx_load = tx_load_q;
    assign bus.tx_data = tx_data_q;

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter: BYTE_W, default 8, data byte width.
REQ-002 Parameter: DEPTH, default 16, FIFO entries; SHALL be a power of two and at least 2.
REQ-003 Port: sys_clk  input  1  single clock; all state on its rising edge.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: flush  input  1  synchronous clear of FIFO contents and the ovf flag.
REQ-006 Port: wr_en  input  1  producer write strobe, one byte per cycle.
REQ-007 Port: wr_data  input  BYTE_W  byte to enqueue.
REQ-008 Port: full  output  1  FIFO holds DEPTH bytes.
REQ-009 Port: empty  output  1  FIFO holds 0 bytes.
REQ-010 Port: count  output  log2(DEPTH)+1  current occupancy.
REQ-011 Port: ovf  output  1  sticky flag, set when a write is dropped.
REQ-012 Port: tx_load  output  1  load strobe to the downstream 8N1 transmitter.
REQ-013 Port: tx_data  output  BYTE_W  byte presented to the transmitter.
REQ-014 Port: load_ok  input  1  transmitter idle and able to accept a byte.

Function
REQ-015 Storage: circular buffer with rd_ptr and wr_ptr, each log2(DEPTH) bits, wrapping modulo DEPTH; count tracks occupancy.
REQ-016 full and empty are combinational decodes of count; full = (count == DEPTH), empty = (count == 0).
REQ-017 Write: wr_en high and not full -> store wr_data at wr_ptr, increment wr_ptr.
REQ-018 Write while full, without a pop in the same cycle -> data dropped, pointers unchanged, ovf set to 1.
REQ-019 A pop and a write in the same cycle both complete, including when full; count is then unchanged.
REQ-020 Drain FSM has three states: IDLE, LOAD, WAIT_ACK.
REQ-021 IDLE -> LOAD when not empty and load_ok = 1; on that edge tx_data <= mem[rd_ptr], rd_ptr increments (pop), and tx_load <= 1.
REQ-022 LOAD lasts exactly 1 cycle; tx_load deasserts on exit; LOAD -> WAIT_ACK.
REQ-023 WAIT_ACK -> IDLE when load_ok = 0, meaning the transmitter accepted the byte; otherwise it holds.
REQ-024 tx_load SHALL be a single-cycle registered pulse; at most one pulse per accepted byte.
REQ-025 tx_data SHALL hold its value from the LOAD edge until the next LOAD edge.
REQ-026 Latency: wr_en into an empty FIFO sampled at edge N, with load_ok = 1 -> tx_load high during the cycle after edge N+1.
REQ-027 flush clears pointers, count and ovf, and returns the FSM to IDLE with tx_load = 0; flush takes priority over wr_en on the same edge.
REQ-028 flush does not recall a byte already presented; tx_data keeps its last value.

Reset
REQ-029 rst_n low -> asynchronously: rd_ptr = wr_ptr = 0, count = 0, FSM = IDLE, tx_load = 0, tx_data = 0, ovf = 0.
REQ-030 Outputs at reset: empty = 1, full = 0.
REQ-031 Memory contents are not reset.
REQ-032 Reset asserted mid-transfer aborts the drain; no tx_load is issued while rst_n is low or on the first edge after release.

Structure
REQ-033 Shared package uart_pkg holds: the FSM state enumeration (IDLE, LOAD, WAIT_ACK), the default BYTE_W and DEPTH, and the pointer-width function (clog2).
REQ-034 One sub-module, uart_fifo_mem: simple dual-port register array with synchronous write and asynchronous read; the FSM and pointer logic stay in uart_tx_fifo.

Verification
REQ-035 Single byte: write 8'h41 with load_ok = 1 -> one tx_load pulse with tx_data = 8'h41 two edges later; empty = 1 afterwards.
REQ-036 Backpressure: write 8'h41, 8'h42, 8'h43 with load_ok = 0 -> no tx_load; raise load_ok, and drop it for 1 cycle after each pulse -> bytes emerge 41, 42, 43 in order, one pulse each.
REQ-037 Overflow: with DEPTH = 16, write 17 bytes with load_ok = 0 -> full = 1, count = 16, ovf = 1; the drained sequence is the first 16 bytes only.
REQ-038 Simultaneous: when full, write 8'h0A on the same edge as a pop -> ovf stays 0, count stays 16, and 8'h0A is drained last.
REQ-039 Wrap: stream 40 bytes (8'h00 .. 8'h27) through DEPTH = 16 with random load_ok gaps -> output order is exact, with no loss or duplication.
REQ-040 Flush/reset: pulse flush, and separately assert rst_n, while in WAIT_ACK with 5 bytes queued -> count = 0, empty = 1, ovf = 0, tx_load = 0, FSM in IDLE.
